// File: rtl/calc_pkg.sv
// Shared definitions for the CalculateUnit issue scheduler: mode codes, operation classes
// and the error-bit layout of rsp_error.
package calc_pkg;

    localparam logic [7:0] CALC_MODE_SUB    = 8'h00;
    localparam logic [7:0] CALC_MODE_ADD    = 8'h01;
    localparam logic [7:0] CALC_MODE_AND    = 8'h10;
    localparam logic [7:0] CALC_MODE_OR     = 8'h11;
    localparam logic [7:0] CALC_MODE_XOR    = 8'h12;
    localparam logic [7:0] CALC_MODE_SLL    = 8'h30;
    localparam logic [7:0] CALC_MODE_SRL    = 8'h31;
    localparam logic [7:0] CALC_MODE_SRA    = 8'h32;
    localparam logic [7:0] CALC_MODE_MUL    = 8'h40;
    localparam logic [7:0] CALC_MODE_MULH   = 8'h41;
    localparam logic [7:0] CALC_MODE_MULHSU = 8'h42;
    localparam logic [7:0] CALC_MODE_MULHU  = 8'h43;
    localparam logic [7:0] CALC_MODE_DIV    = 8'h44;
    localparam logic [7:0] CALC_MODE_DIVU   = 8'h45;
    localparam logic [7:0] CALC_MODE_REM    = 8'h46;
    localparam logic [7:0] CALC_MODE_REMU   = 8'h47;

    localparam int unsigned CALC_ERR_ILLEGAL = 3;

    typedef enum logic [1:0] {
        ClsFast,
        ClsMul,
        ClsDiv,
        ClsIllegal
    } calc_class_e;

    // 0x40..0x47 share mode[7:3]; mode[2] splits multiply from divide/remainder.
    function automatic calc_class_e calc_mode_class(input logic [7:0] mode);
        calc_class_e cls;
        cls = ClsIllegal;
        if (mode[7:4] == 4'h0 || mode[7:4] == 4'h1 || mode[7:4] == 4'h3) begin
            cls = ClsFast;
        end else if (mode[7:3] == 5'b01000) begin
            cls = mode[2] ? ClsDiv : ClsMul;
        end
        return cls;
    endfunction

endpackage

// File: rtl/calc_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the requester that wins a tie and moves
// to the losing side after every grant; grants are only issued while free_i is high.
module calc_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       free_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (free_i) begin
            if (&valid_i) begin
                grant_o[ptr_q] = 1'b1;
            end else begin
                grant_o = valid_i;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_o[0]) begin
            ptr_d = 1'b1;
        end else if (grant_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/calc_unit_sched.sv
// Issue scheduler for the shared CalculateUnit: arbitrates two requesters, holds operands on
// cu_* and returns the result after the class latency. Build macro: CALC_DIVZERO_SHORTCUT_EN.
module calc_unit_sched
    import calc_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_num1,
    input  logic [31:0] req0_num2,
    input  logic [7:0]  req0_mode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_num1,
    input  logic [31:0] req1_num2,
    input  logic [7:0]  req1_mode,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_error,
    output logic [31:0] cu_number1,
    output logic [31:0] cu_number2,
    output logic [7:0]  cu_mode,
    input  logic [31:0] cu_fast_answer,
    input  logic [31:0] cu_slow_answer,
    input  logic [3:0]  cu_error
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            id_q, id_d;
    calc_class_e     cls_q, cls_d;
    logic [31:0]     num1_q, num1_d;
    logic [31:0]     num2_q, num2_d;
    logic [7:0]      mode_q, mode_d;
`ifdef CALC_DIVZERO_SHORTCUT_EN
    logic            dz_q, dz_d;
`endif

    logic        free;
    logic        accept;
    logic [1:0]  grant;
    logic [31:0] sel_num1, sel_num2;
    logic [7:0]  sel_mode;
    calc_class_e sel_cls;
    logic        unused_cu_error;

    // Only the MDU error bits are forwarded; the upper CalculateUnit error bits are ignored.
    assign unused_cu_error = ^cu_error[3:2];

    assign free = !rst && ((state_q == StIdle) || ((state_q == StBusy) && (cnt_q == '0)));

    calc_rr_arb2 u_arb (
        .clk_i   (clk),
        .rst_i   (rst),
        .free_i  (free),
        .valid_i ({req1_valid, req0_valid}),
        .grant_o (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;

    assign sel_num1 = grant[1] ? req1_num1 : req0_num1;
    assign sel_num2 = grant[1] ? req1_num2 : req0_num2;
    assign sel_mode = grant[1] ? req1_mode : req0_mode;
    assign sel_cls  = calc_mode_class(sel_mode);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        cls_d   = cls_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        mode_d  = mode_q;
`ifdef CALC_DIVZERO_SHORTCUT_EN
        dz_d    = dz_q;
`endif
        if (state_q == StBusy) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CntOne;
            end else begin
                state_d = StIdle;
            end
        end
        // A new accept overrides the return to idle when it coincides with a response.
        if (accept) begin
            state_d = StBusy;
            id_d    = grant[1];
            cls_d   = sel_cls;
            num1_d  = sel_num1;
            num2_d  = sel_num2;
            mode_d  = sel_mode;
            case (sel_cls)
                ClsMul:  cnt_d = CntW'(MUL_LAT);
                ClsDiv:  cnt_d = CntW'(DIV_LAT);
                default: cnt_d = '0;
            endcase
`ifdef CALC_DIVZERO_SHORTCUT_EN
            dz_d = (sel_cls == ClsDiv) && (sel_num2 == '0);
            if (dz_d) begin
                cnt_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            cls_q   <= ClsFast;
            num1_q  <= '0;
            num2_q  <= '0;
            mode_q  <= '0;
`ifdef CALC_DIVZERO_SHORTCUT_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            cls_q   <= cls_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            mode_q  <= mode_d;
`ifdef CALC_DIVZERO_SHORTCUT_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign cu_number1 = num1_q;
    assign cu_number2 = num2_q;
    assign cu_mode    = mode_q;

    always_comb begin
        rsp_valid = (state_q == StBusy) && (cnt_q == '0);
        rsp_id    = 1'b0;
        rsp_data  = '0;
        rsp_error = '0;
        if (rsp_valid) begin
            rsp_id = id_q;
            case (cls_q)
                ClsFast: rsp_data = cu_fast_answer;
                ClsMul, ClsDiv: begin
                    rsp_data  = cu_slow_answer;
                    rsp_error = {2'b00, cu_error[1:0]};
                end
                default: rsp_error[CALC_ERR_ILLEGAL] = 1'b1;
            endcase
`ifdef CALC_DIVZERO_SHORTCUT_EN
            // mode[1] separates REM/REMU (dividend back) from DIV/DIVU (all ones).
            if (dz_q) begin
                rsp_data  = mode_q[1] ? num1_q : 32'hFFFF_FFFF;
                rsp_error = '0;
            end
`endif
        end
    end

endmodule

// File: doc/calc_unit_sched.md
# calc_unit_sched

Issue scheduler for the CalculateUnit shared datapath. Two requesters (integer pipe, debug/CSR port) compete under round-robin arbitration; the block registers the winner's operands onto the unit's inputs and holds them stable. It then returns the fast answer after 1 cycle, or the multiply/divide result after a fixed latency. It sits between the execute-stage issue logic and the CalculateUnit instance.

## Interface
Parameters:
- MUL_LAT, 1: cycles from operand registration to a valid MUL-class result (≥1).
- DIV_LAT, 32: the same for DIV/REM-class results (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reqN_valid  in  1  request from requester N (N = 0,1)
- reqN_ready  out  1  request N accepted this cycle
- reqN_num1, reqN_num2  in  32  operands
- reqN_mode  in  8  CalculateUnit mode code
- rsp_valid  out  1  result valid (single-cycle pulse, no backpressure)
- rsp_id  out  1  requester that owns the result
- rsp_data  out  32  result
- rsp_error  out  4  [1:0] MDU error, [2] reserved 0, [3] illegal mode
- cu_number1, cu_number2  out  32  registered operands to CalculateUnit
- cu_mode  out  8  registered mode to CalculateUnit
- cu_fast_answer, cu_slow_answer  in  32  CalculateUnit results
- cu_error  in  4  CalculateUnit error

## Operation
- Mode classes, from mode[7:4]:
  - FAST: 0x0, 0x1, 0x3.
  - MUL: 0x40–0x43.
  - DIV: 0x44–0x47.
  - ILLEGAL: anything else.
- States:
  - IDLE: nothing in flight.
  - BUSY: one op in flight, with down-counter cnt.
- Accept condition, `free = (IDLE) || (BUSY && cnt==0)`. Acceptance occurs when free and at least one reqN_valid is high. Only the granted requester sees reqN_ready=1.
- On accept:
  - Latch operands and mode into the cu_* registers and latch the id.
  - Load cnt with 0 (FAST/ILLEGAL), MUL_LAT (MUL) or DIV_LAT (DIV).
  - Go to BUSY.
- In BUSY:
  - If cnt≠0, decrement cnt.
  - If cnt==0, assert rsp_valid. rsp_data is cu_fast_answer (FAST), cu_slow_answer (MUL/DIV) or 0 (ILLEGAL). Then go to IDLE, or stay in BUSY if a new op is accepted in the same cycle.
- rsp_error:
  - {1'b0, 1'b0, cu_error[1:0]} for MUL/DIV.
  - 4'b1000 for ILLEGAL.
  - 0 otherwise.
- Arbitration:
  - 1-bit priority pointer; the pointer's requester wins ties.
  - After any grant, the pointer moves to the non-granted requester.
  - A lone valid requester always wins.
- Requester rules: valid must not drop and operands must stay stable while valid && !ready.
- cnt width: clog2(max(MUL_LAT, DIV_LAT)+1).

## Timing
- Accept at cycle N gives these response cycles:
  - FAST/ILLEGAL: rsp in N+1.
  - MUL: rsp in N+1+MUL_LAT.
  - DIV: rsp in N+1+DIV_LAT.
- Throughput: one FAST op per cycle (accept coincides with the previous response).
- cu_* outputs are stable from N+1 until the response cycle inclusive.
- Reset values:
  - state IDLE, cnt 0, pointer → req0.
  - cu_number1/2 = 0, cu_mode = 0x00.
  - rsp_valid 0, rsp_id 0, rsp_data 0, rsp_error 0.
  - reqN_ready 0 while rst is high.
- Reset mid-operation: the in-flight op is discarded with no response. The first accept is possible in the first cycle after rst deasserts.
- Simultaneous response and new accept: the response belongs to the old id. The new op's operands appear on cu_* in the following cycle.

## Configuration
- CALC_DIVZERO_SHORTCUT_EN defined: a DIV-class op with num2==0 loads cnt=0 and responds in N+1 with rsp_error=0.
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return num1.
- Undefined: divide-by-zero takes the full DIV_LAT, and the CalculateUnit result and error pass through unchanged.

## Structure
- Shared package calc_pkg holds:
  - mode code localparams (SUB…REMU).
  - class enum (FAST, MUL, DIV, ILLEGAL) and a mode→class function.
  - error bit index constant CALC_ERR_ILLEGAL=3.
- Sub-module calc_rr_arb2: two-input round-robin arbiter with the priority pointer; outputs a one-hot grant qualified by `free`.

## Test plan
- Reset, then req0 ADD(0x01) 5,7 accepted in N → rsp_valid in N+1, rsp_data=12, rsp_id=0, rsp_error=0.
- req0 SUB 10,3 and req1 XOR 0xF0,0x0F valid together after reset → req0 granted N, req1 granted N+1. Responses: N+1 data 7 id 0, N+2 data 0xFF id 1. Next tie → req0 wins.
- MUL(0x40) 6,7 with MUL_LAT=1 → req ready low in N+1, rsp in N+2 data 42. Back-to-back FAST op accepted in N+2 → rsp in N+3.
- DIV(0x44) 100,7 with DIV_LAT=32 → rsp in N+33 data 14. No readys in N+1..N+32. With macro, DIV 5,0 → rsp N+1 0xFFFFFFFF; REMU 5,0 → 5.
- mode 0x55 → rsp in N+1, data 0, rsp_error=4'b1000.
- rst pulsed at N+10 during a DIV → no rsp_valid ever for it. cu_mode=0, state IDLE, new ADD accepted the first cycle after release.
